key_counter_4_bits: RTL and testbench

- Upstream source stage for the 4-bit binary-to-BCD seven-segment decoder.
- Takes three raw active-low pushbuttons (up, down, load) and a 4-bit switch bank.
- Synchronises and debounces each button, turns each press into a single event, and maintains a wrapping 4-bit count 0..15.
- The count drives the decoder's 4-bit input directly.

---
 rtl/key_counter_4_bits.sv | 103 ++++++++++
 tb/tb_key_counter_4_bits.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_counter_4_bits.sv
// Pushbutton front end for the BCD display path: synchronises, debounces and
// edge-detects three active-low keys, and keeps a wrapping 4-bit count.
module key_counter_4_bits #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic [3:0]  RESET_VALUE     = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_up_n,
    input  logic       key_down_n,
    input  logic       key_load_n,
    input  logic [3:0] sw,
    output logic [3:0] x,
    output logic       wrap
);
    localparam int unsigned KEYS   = 3;
    localparam int unsigned K_UP   = 0;
    localparam int unsigned K_DOWN = 1;
    localparam int unsigned K_LOAD = 2;
    localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

    logic [KEYS-1:0]       key_raw;
    logic [KEYS-1:0]       sync1_q;
    logic [KEYS-1:0]       sync2_q;
    logic [KEYS-1:0]       lvl_q;
    logic [KEYS-1:0]       lvl_d;
    logic [KEYS-1:0]       lvl_dly_q;
    logic [KEYS-1:0]       press_q;
    logic [KEYS-1:0]       press_d;
    logic [KEYS-1:0][19:0] cnt_q;
    logic [KEYS-1:0][19:0] cnt_d;
    logic [3:0]            sw_sync1_q;
    logic [3:0]            sw_sync2_q;
    logic [3:0]            x_q;
    logic [3:0]            x_d;
    logic                  wrap_q;
    logic                  wrap_d;

    assign key_raw = {key_load_n, key_down_n, key_up_n};

    // Any sample matching the accepted level restarts the stability interval.
    always_comb begin
        lvl_d = lvl_q;
        cnt_d = cnt_q;
        for (int k = 0; k < KEYS; k++) begin
            if (sync2_q[k] == lvl_q[k]) begin
                cnt_d[k] = 20'd0;
            end else if (cnt_q[k] == CNT_LAST) begin
                lvl_d[k] = sync2_q[k];
                cnt_d[k] = 20'd0;
            end else begin
                cnt_d[k] = cnt_q[k] + 20'd1;
            end
        end
    end

    // The delayed level copy lets the press pulse register one cycle after
    // the accepted 1->0 change, giving a fixed DEBOUNCE_CYCLES+3 latency.
    assign press_d = lvl_dly_q & ~lvl_q;

    always_comb begin
        x_d    = x_q;
        wrap_d = 1'b0;
        if (press_q[K_LOAD]) begin
            x_d = sw_sync2_q;
        end else if (press_q[K_UP] && !press_q[K_DOWN]) begin
            x_d    = x_q + 4'd1;
            wrap_d = (x_q == 4'hF);
        end else if (press_q[K_DOWN] && !press_q[K_UP]) begin
            x_d    = x_q - 4'd1;
            wrap_d = (x_q == 4'h0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            lvl_q      <= '1;
            lvl_dly_q  <= '1;
            press_q    <= '0;
            cnt_q      <= '0;
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
            x_q        <= RESET_VALUE;
            wrap_q     <= 1'b0;
        end else begin
            sync1_q    <= key_raw;
            sync2_q    <= sync1_q;
            lvl_q      <= lvl_d;
            lvl_dly_q  <= lvl_q;
            press_q    <= press_d;
            cnt_q      <= cnt_d;
            sw_sync1_q <= sw;
            sw_sync2_q <= sw_sync1_q;
            x_q        <= x_d;
            wrap_q     <= wrap_d;
        end
    end

    assign x    = x_q;
    assign wrap = wrap_q;
endmodule

// File: tb/tb_key_counter_4_bits.sv
// Bench for key_counter_4_bits with a short debounce interval; directed
// scenarios plus randomised key activity scored against a window-based model.
module tb_key_counter_4_bits;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_up_n;
    logic       key_down_n;
    logic       key_load_n;
    logic [3:0] sw;
    logic [3:0] x;
    logic       wrap;

    int errors = 0;
    int checks = 0;

    key_counter_4_bits #(
        .DEBOUNCE_CYCLES(D),
        .RESET_VALUE    (4'd0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_up_n  (key_up_n),
        .key_down_n(key_down_n),
        .key_load_n(key_load_n),
        .sw        (sw),
        .x         (x),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    // Reference model: m_hist[k][i] is the raw key level sampled i+1 edges
    // ago. A key's accepted level flips once the last D synchronised samples
    // (ages 2..D+1) all disagree with it; a 1->0 flip acts on x two edges later.
    bit         m_hist [3][D+1];
    bit         m_lvl  [3];
    bit   [2:0] m_pend1;
    bit   [2:0] m_pend2;
    bit   [2:0] m_flip;
    bit   [2:0] m_raw;
    bit         m_all_diff;
    logic [3:0] m_sw1;
    logic [3:0] m_sw2;
    logic [3:0] m_x;
    logic       m_wrap;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i <= D; i++) m_hist[k][i] = 1'b1;
                m_lvl[k] = 1'b1;
            end
            m_pend1 = '0;
            m_pend2 = '0;
            m_sw1   = '0;
            m_sw2   = '0;
            m_x     = 4'd0;
            m_wrap  = 1'b0;
        end else begin
            m_wrap = 1'b0;
            if (m_pend2[2]) begin
                m_x = m_sw2;
            end else if (m_pend2[0] && !m_pend2[1]) begin
                m_wrap = (m_x == 4'd15);
                m_x    = 4'((int'(m_x) + 1) % 16);
            end else if (m_pend2[1] && !m_pend2[0]) begin
                m_wrap = (m_x == 4'd0);
                m_x    = 4'((int'(m_x) + 15) % 16);
            end
            m_flip = '0;
            for (int k = 0; k < 3; k++) begin
                m_all_diff = 1'b1;
                for (int i = 1; i <= D; i++)
                    if (m_hist[k][i] == m_lvl[k]) m_all_diff = 1'b0;
                if (m_all_diff) begin
                    if (m_lvl[k]) m_flip[k] = 1'b1;
                    m_lvl[k] = !m_lvl[k];
                end
            end
            m_pend2 = m_pend1;
            m_pend1 = m_flip;
            m_raw = {key_load_n, key_down_n, key_up_n};
            for (int k = 0; k < 3; k++) begin
                for (int i = D; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
                m_hist[k][0] = m_raw[k];
            end
            m_sw2 = m_sw1;
            m_sw1 = sw;
        end
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        key_up_n   = 1'b1;
        key_down_n = 1'b1;
        key_load_n = 1'b1;
        sw         = 4'h0;
        rst_n      = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (x !== 4'd0) begin
            errors++;
            $display("FAIL reset_async_x: x=%0d expected 0", x);
        end
        checks++;
        if (wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_wrap: wrap=%b expected 0", wrap);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if (x !== 4'd0 || wrap !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d: x=%0d wrap=%b expected x=0 wrap=0", i, x, wrap);
            end
        end
    endtask

    task automatic test_up_press;
        logic [3:0] exp_x;
        key_up_n = 1'b0;
        for (int e = 0; e <= 20; e++) begin
            tick();
            exp_x = (e >= D + 3) ? 4'd1 : 4'd0;
            checks++;
            if (x !== exp_x || wrap !== 1'b0) begin
                errors++;
                $display("FAIL up_press edge=%0d: x=%0d wrap=%b expected x=%0d wrap=0", e, x, wrap, exp_x);
            end
        end
        key_up_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (x !== 4'd1 || wrap !== 1'b0) begin
                errors++;
                $display("FAIL up_release cyc=%0d: x=%0d wrap=%b expected x=1 wrap=0", i, x, wrap);
            end
        end
    endtask

    task automatic test_bounce;
        logic [3:0] exp_x;
        logic       exp_w;
        apply_reset();
        for (int r = 0; r < 5; r++) begin
            key_down_n = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (i == 3) key_down_n = 1'b1;
                tick();
                checks++;
                if (x !== 4'd0 || wrap !== 1'b0) begin
                    errors++;
                    $display("FAIL bounce r=%0d i=%0d: x=%0d wrap=%b expected x=0 wrap=0", r, i, x, wrap);
                end
            end
        end
        key_down_n = 1'b0;
        for (int e = 0; e <= 12; e++) begin
            tick();
            exp_x = (e >= D + 3) ? 4'd15 : 4'd0;
            exp_w = (e == D + 3);
            checks++;
            if (x !== exp_x || wrap !== exp_w) begin
                errors++;
                $display("FAIL down_after_bounce edge=%0d: x=%0d wrap=%b expected x=%0d wrap=%b", e, x, wrap, exp_x, exp_w);
            end
        end
        key_down_n = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_wrap_up;
        logic [3:0] exp_x;
        logic       exp_w;
        sw         = 4'hF;
        key_load_n = 1'b0;
        repeat (12) tick();
        key_load_n = 1'b1;
        repeat (10) tick();
        checks++;
        if (x !== 4'd15) begin
            errors++;
            $display("FAIL load_f: x=%0d expected 15", x);
        end
        key_up_n = 1'b0;
        for (int e = 0; e <= 10; e++) begin
            tick();
            exp_x = (e >= D + 3) ? 4'd0 : 4'd15;
            exp_w = (e == D + 3);
            checks++;
            if (x !== exp_x || wrap !== exp_w) begin
                errors++;
                $display("FAIL wrap_up edge=%0d: x=%0d wrap=%b expected x=%0d wrap=%b", e, x, wrap, exp_x, exp_w);
            end
        end
        key_up_n = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_simultaneous;
        logic [3:0] exp_x;
        sw         = 4'h7;
        key_load_n = 1'b0;
        repeat (12) tick();
        key_load_n = 1'b1;
        repeat (10) tick();
        checks++;
        if (x !== 4'd7) begin
            errors++;
            $display("FAIL load_7: x=%0d expected 7", x);
        end
        for (int r = 0; r < 3; r++) begin
            key_up_n   = 1'b0;
            key_down_n = 1'b0;
            repeat (2) tick();
            key_up_n   = 1'b1;
            key_down_n = 1'b1;
            tick();
        end
        key_up_n   = 1'b0;
        key_down_n = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            checks++;
            if (x !== 4'd7 || wrap !== 1'b0) begin
                errors++;
                $display("FAIL up_down_together cyc=%0d: x=%0d wrap=%b expected x=7 wrap=0", i, x, wrap);
            end
        end
        key_up_n   = 1'b1;
        key_down_n = 1'b1;
        repeat (10) tick();
        sw         = 4'h3;
        key_load_n = 1'b0;
        key_up_n   = 1'b0;
        for (int e = 0; e <= 12; e++) begin
            tick();
            exp_x = (e >= D + 3) ? 4'd3 : 4'd7;
            checks++;
            if (x !== exp_x || wrap !== 1'b0) begin
                errors++;
                $display("FAIL load_with_up edge=%0d: x=%0d wrap=%b expected x=%0d wrap=0", e, x, wrap, exp_x);
            end
        end
        key_load_n = 1'b1;
        key_up_n   = 1'b1;
        repeat (10) tick();
        checks++;
        if (x !== 4'd3) begin
            errors++;
            $display("FAIL load_with_up_final: x=%0d expected 3", x);
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] exp_x;
        key_up_n = 1'b0;
        repeat (4) tick();
        checks++;
        if (x !== 4'd3) begin
            errors++;
            $display("FAIL mid_debounce_hold: x=%0d expected 3", x);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (x !== 4'd0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: x=%0d wrap=%b expected x=0 wrap=0", x, wrap);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e <= 10; e++) begin
            tick();
            exp_x = (e >= D + 3) ? 4'd1 : 4'd0;
            checks++;
            if (x !== exp_x || wrap !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_repress edge=%0d: x=%0d wrap=%b expected x=%0d wrap=0", e, x, wrap, exp_x);
            end
        end
        key_up_n = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_random;
        int hold [3];
        bit lvl  [3];
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            hold[k] = 1;
            lvl[k]  = 1'b1;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 3; k++) begin
                hold[k]--;
                if (hold[k] <= 0) begin
                    lvl[k]  = !lvl[k];
                    hold[k] = (lvl[k] == 1'b0) ? $urandom_range(1, 2 * D + 2) : $urandom_range(1, 3 * D);
                end
            end
            key_up_n   = lvl[0];
            key_down_n = lvl[1];
            key_load_n = lvl[2];
            if ($urandom_range(0, 7) == 0) sw = 4'($urandom_range(0, 15));
            tick();
            checks++;
            if (x !== m_x || wrap !== m_wrap) begin
                errors++;
                $display("FAIL random cyc=%0d: x=%0d wrap=%b model x=%0d wrap=%b", c, x, wrap, m_x, m_wrap);
            end
        end
        key_up_n   = 1'b1;
        key_down_n = 1'b1;
        key_load_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_up_press();
        test_bounce();
        test_wrap_up();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
